axi_line_master: RTL and testbench
==================================

# axi_line_master

Parametrised AXI4 master port that replaces the single-beat CPU-side master behind the CPU wrapper's instruction and data ports. It accepts one request per transaction from a cache or CPU client: a read of 1..MAX_BEATS words, or a write of 1..MAX_BEATS words. It issues the request as an INCR burst on the AXI read or write channels, collects the data into a line buffer, and returns a single response pulse with error status. One instance sits per AXI master port; the wrapper instantiates one for IM refill and one for DM.

## Interface
- Reset ARESETn, asynchronous, active-low; clock ACLK.
- ID_W, 4: AXI ID width.
- ADDR_W, 32: address width.
- DATA_W, 32: data width, power of two ≥ 8.
- MAX_BEATS, 4: line size in beats; power of two, 1..16.
- MASTER_ID, 0: constant driven on ARID/AWID, expected on RID/BID.
- ACLK  in  1  clock.
- ARESETn  in  1  async active-low reset.
- req_valid  in  1  request strobe.
- req_ready  out  1  block idle, request accepted when both high.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  start address, aligned to DATA_W/8.
- req_len  in  LW=max(1,clog2(MAX_BEATS))  beats−1.
- req_wstrb  in  DATA_W/8  byte strobe, applied to every write beat.
- req_wdata  in  MAX_BEATS*DATA_W  write line, beat k at bits [k*DATA_W +: DATA_W].
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_err  out  1  error flag, valid with rsp_valid.
- rsp_rdata  out  MAX_BEATS*DATA_W  read line, same packing as req_wdata. Held until the next read completes.
- busy  out  1  state ≠ IDLE; the CPU uses it as stall.
- AR*: ARID, ARADDR, ARLEN[3:0], ARSIZE[2:0], ARBURST[1:0], ARVALID out; ARREADY in.
- R*: RID, RDATA, RRESP[1:0], RLAST, RVALID in; RREADY out.
- AW*: same fields as AR*.
- W*: WDATA, WSTRB, WLAST, WVALID out; WREADY in.
- B*: BID, BRESP[1:0], BVALID in; BREADY out.

## Operation
- States: IDLE, AR, R, AW, W, B, RESP.
- IDLE:
  - req_ready=1.
  - On handshake, latch addr, len, write, wstrb, wdata; clear the beat counter and error flag.
  - Go to AW if write, else AR.
- AR: ARVALID=1, fields held stable until ARREADY, then → R.
  - ARADDR = latched addr.
  - ARLEN = len zero-extended to 4 bits.
  - ARSIZE = log2(DATA_W/8).
  - ARBURST = 2'b01 (INCR).
  - ARID = MASTER_ID.
- R: RREADY=1. On each RVALID handshake:
  - Store RDATA into line slot[beat] and increment beat.
  - Error if RRESP≠2'b00 or RID≠MASTER_ID.
  - RLAST with beat≠len: error, → RESP.
  - beat==len without RLAST: store the beat, error, stay in R and drop further beats until RLAST, then → RESP.
  - Correct RLAST: → RESP.
- AW: same field rules as AR on the AW channel, → W on AWREADY. WVALID is never asserted before the AW handshake completes.
- W: WVALID=1, WDATA = line slot[beat], WSTRB = latched wstrb, WLAST = (beat==len).
  - Each WREADY handshake increments beat.
  - Handshake with WLAST → B.
- B: BREADY=1. On BVALID:
  - Error if BRESP≠0 or BID≠MASTER_ID.
  - → RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle, rsp_err = accumulated error, → IDLE.
  - The client always accepts; there is no rsp_ready.
- Beat counter: LW+1 bits, never wraps within a burst.
- Read slots above len keep their previous contents.

## Timing
- Reset values:
  - All VALID/READY outputs 0, req_ready 0, busy 0.
  - rsp_valid and rsp_err 0; rsp_rdata all-zero.
  - ARADDR/AWADDR, ARLEN/AWLEN and WDATA 0.
  - ARSIZE/AWSIZE 0, ARBURST/AWBURST 0, IDs 0.
- From reset release: req_ready rises on the first ACLK edge with ARESETn high.
- Request accepted at edge T → ARVALID/AWVALID high from T+1.
- Zero-wait slave, read of N beats: AR handshake at T+1, R beats T+2..T+N+1, rsp_valid at T+N+2.
- Zero-wait slave, write of N beats: AW at T+1, W beats T+2..T+N+1, B accepted ≥ T+N+2, rsp_valid the cycle after the B handshake.
- VALID, once asserted, stays high with stable payload until READY. No combinational path from any AXI READY to any VALID.
- req_ready is 0 from the acceptance edge until the cycle after rsp_valid; back-to-back requests have ≥1 IDLE cycle between them.
- Reset mid-transaction: immediate return to IDLE with reset values. No response is generated for the aborted request.

## Test plan
- Read burst: MAX_BEATS=4, req addr 0x0000_1000, len 3, zero-wait slave returning 0xA0..0xA3 → one AR with ARLEN=3, ARSIZE=2, ARBURST=1; rsp_rdata={0xA3,0xA2,0xA1,0xA0}, rsp_err=0, rsp_valid 6 cycles after accept.
- Write burst: len 1, wdata beats 0x1111_1111/0x2222_2222, wstrb 4'b0011, WREADY low 2 cycles per beat → WDATA/WSTRB stable while stalled, WLAST only on beat 1, BRESP=0 gives rsp_err=0.
- Single-beat read: len 0, slave returns RRESP=2'b10 → ARLEN=0, rsp_err=1, slot 0 updated, other slots unchanged.
- Early RLAST: len 3, RLAST on beat 1 → rsp_err=1, response issued, block returns to IDLE and accepts the next request.
- ARREADY held low 10 cycles → ARVALID and ARADDR constant throughout, busy=1, req_ready=0.
- ARESETn pulsed low during the W phase → all valids 0 asynchronously, no rsp_valid; next request completes normally.

Source files
------------

// File: rtl/axi_line_master.sv
// rtl/axi_line_master.sv - AXI4 burst master serving one line read or write per client request
module axi_line_master #(
    parameter  int ID_W      = 4,
    parameter  int ADDR_W    = 32,
    parameter  int DATA_W    = 32,
    parameter  int MAX_BEATS = 4,
    parameter  int MASTER_ID = 0,
    localparam int LW        = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1,
    localparam int SW        = DATA_W / 8,
    localparam int LINE_W    = MAX_BEATS * DATA_W
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LW-1:0]     req_len,
    input  logic [SW-1:0]     req_wstrb,
    input  logic [LINE_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [LINE_W-1:0] rsp_rdata,
    output logic              busy,
    output logic [ID_W-1:0]   ARID,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [3:0]        ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [ID_W-1:0]   RID,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY,
    output logic [ID_W-1:0]   AWID,
    output logic [ADDR_W-1:0] AWADDR,
    output logic [3:0]        AWLEN,
    output logic [2:0]        AWSIZE,
    output logic [1:0]        AWBURST,
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [DATA_W-1:0] WDATA,
    output logic [SW-1:0]     WSTRB,
    output logic              WLAST,
    output logic              WVALID,
    input  logic              WREADY,
    input  logic [ID_W-1:0]   BID,
    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY
);

    localparam logic [2:0]      AX_SIZE = 3'($clog2(SW));
    localparam logic [ID_W-1:0] MID     = ID_W'(MASTER_ID);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_RESP} state_t;

    state_t              state_q, state_d;
    logic                req_ready_q, req_ready_d, busy_q, busy_d;
    logic                write_q, write_d, err_q, err_d, drop_q, drop_d;
    logic [LW-1:0]       len_q, len_d;
    logic [LW:0]         beat_q, beat_d;
    logic [SW-1:0]       wstrb_q, wstrb_d;
    logic [LINE_W-1:0]   line_q, line_d, rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_W-1:0]   ax_addr_q, ax_addr_d;
    logic [3:0]          ax_len_q, ax_len_d;
    logic [2:0]          ax_size_q, ax_size_d;
    logic [1:0]          ax_burst_q, ax_burst_d;
    logic [ID_W-1:0]     ax_id_q, ax_id_d;
    logic                arvalid_q, arvalid_d, awvalid_q, awvalid_d, rready_q, rready_d;
    logic                wvalid_q, wvalid_d, wlast_q, wlast_d, bready_q, bready_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        err_d       = err_q;
        drop_d      = drop_q;
        len_d       = len_q;
        beat_d      = beat_q;
        wstrb_d     = wstrb_q;
        line_d      = line_q;
        rsp_rdata_d = rsp_rdata_q;
        ax_addr_d   = ax_addr_q;
        ax_len_d    = ax_len_q;
        ax_size_d   = ax_size_q;
        ax_burst_d  = ax_burst_q;
        ax_id_d     = ax_id_q;
        arvalid_d   = arvalid_q;
        awvalid_d   = awvalid_q;
        rready_d    = rready_q;
        wvalid_d    = wvalid_q;
        wlast_d     = wlast_q;
        wdata_d     = wdata_q;
        bready_d    = bready_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    write_d    = req_write;
                    len_d      = req_len;
                    wstrb_d    = req_wstrb;
                    // Reads start from the last returned line so untouched slots persist.
                    line_d     = req_write ? req_wdata : rsp_rdata_q;
                    beat_d     = '0;
                    err_d      = 1'b0;
                    drop_d     = 1'b0;
                    ax_addr_d  = req_addr;
                    ax_len_d   = 4'(req_len);
                    ax_size_d  = AX_SIZE;
                    ax_burst_d = 2'b01;
                    ax_id_d    = MID;
                    if (req_write) begin
                        awvalid_d = 1'b1;
                        state_d   = S_AW;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = S_AR;
                    end
                end
            end
            S_AR: begin
                if (ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_R;
                end
            end
            S_R: begin
                if (RVALID) begin
                    if (!drop_q) begin
                        for (int k = 0; k < MAX_BEATS; k++) begin
                            if (beat_q == (LW+1)'(k)) line_d[k*DATA_W +: DATA_W] = RDATA;
                        end
                        beat_d = beat_q + 1'b1;
                        if (RRESP != 2'b00 || RID != MID) err_d = 1'b1;
                        if (RLAST) begin
                            if (beat_q != {1'b0, len_q}) err_d = 1'b1;
                            rready_d = 1'b0;
                            state_d  = S_RESP;
                        end else if (beat_q == {1'b0, len_q}) begin
                            // Slave overran the burst: swallow beats until its RLAST.
                            err_d  = 1'b1;
                            drop_d = 1'b1;
                        end
                    end else if (RLAST) begin
                        rready_d = 1'b0;
                        state_d  = S_RESP;
                    end
                end
            end
            S_AW: begin
                if (AWREADY) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b1;
                    wdata_d   = line_q[0 +: DATA_W];
                    wlast_d   = (len_q == '0);
                    state_d   = S_W;
                end
            end
            S_W: begin
                if (WREADY) begin
                    if (wlast_q) begin
                        wvalid_d = 1'b0;
                        wlast_d  = 1'b0;
                        bready_d = 1'b1;
                        state_d  = S_B;
                    end else begin
                        beat_d = beat_q + 1'b1;
                        for (int k = 0; k < MAX_BEATS; k++) begin
                            if (beat_d == (LW+1)'(k)) wdata_d = line_q[k*DATA_W +: DATA_W];
                        end
                        wlast_d = (beat_d == {1'b0, len_q});
                    end
                end
            end
            S_B: begin
                if (BVALID) begin
                    if (BRESP != 2'b00 || BID != MID) err_d = 1'b1;
                    bready_d = 1'b0;
                    state_d  = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        rsp_err_d   = (state_d == S_RESP) && err_d;
        if (state_d == S_RESP && state_q != S_RESP && !write_q) rsp_rdata_d = line_d;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            drop_q      <= 1'b0;
            len_q       <= '0;
            beat_q      <= '0;
            wstrb_q     <= '0;
            line_q      <= '0;
            rsp_rdata_q <= '0;
            ax_addr_q   <= '0;
            ax_len_q    <= '0;
            ax_size_q   <= '0;
            ax_burst_q  <= '0;
            ax_id_q     <= '0;
            arvalid_q   <= 1'b0;
            awvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            wvalid_q    <= 1'b0;
            wlast_q     <= 1'b0;
            wdata_q     <= '0;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            write_q     <= write_d;
            err_q       <= err_d;
            drop_q      <= drop_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            wstrb_q     <= wstrb_d;
            line_q      <= line_d;
            rsp_rdata_q <= rsp_rdata_d;
            ax_addr_q   <= ax_addr_d;
            ax_len_q    <= ax_len_d;
            ax_size_q   <= ax_size_d;
            ax_burst_q  <= ax_burst_d;
            ax_id_q     <= ax_id_d;
            arvalid_q   <= arvalid_d;
            awvalid_q   <= awvalid_d;
            rready_q    <= rready_d;
            wvalid_q    <= wvalid_d;
            wlast_q     <= wlast_d;
            wdata_q     <= wdata_d;
            bready_q    <= bready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign ARID      = ax_id_q;
    assign ARADDR    = ax_addr_q;
    assign ARLEN     = ax_len_q;
    assign ARSIZE    = ax_size_q;
    assign ARBURST   = ax_burst_q;
    assign ARVALID   = arvalid_q;
    assign RREADY    = rready_q;
    assign AWID      = ax_id_q;
    assign AWADDR    = ax_addr_q;
    assign AWLEN     = ax_len_q;
    assign AWSIZE    = ax_size_q;
    assign AWBURST   = ax_burst_q;
    assign AWVALID   = awvalid_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = wstrb_q;
    assign WLAST     = wlast_q;
    assign WVALID    = wvalid_q;
    assign BREADY    = bready_q;

endmodule

// File: tb/tb_axi_line_master.sv
// tb/tb_axi_line_master.sv - directed checks of axi_line_master with MAX_BEATS=4, DATA_W=32
module tb_axi_line_master;

    logic         ACLK, ARESETn;
    logic         req_valid, req_ready, req_write;
    logic [31:0]  req_addr;
    logic [1:0]   req_len;
    logic [3:0]   req_wstrb;
    logic [127:0] req_wdata;
    logic         rsp_valid, rsp_err, busy;
    logic [127:0] rsp_rdata;
    logic [3:0]   ARID, AWID, RID, BID;
    logic [31:0]  ARADDR, AWADDR, RDATA, WDATA;
    logic [3:0]   ARLEN, AWLEN, WSTRB;
    logic [2:0]   ARSIZE, AWSIZE;
    logic [1:0]   ARBURST, AWBURST, RRESP, BRESP;
    logic         ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic         AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;

    int total = 0;
    int bad   = 0;
    logic [127:0] exp_line;

    axi_line_master dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .busy(busy),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d", total);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic wr, input logic [31:0] a, input logic [1:0] len,
                            input logic [3:0] strb, input logic [127:0] wd);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_len = len;
        req_wstrb = strb; req_wdata = wd;
        @(negedge ACLK);
        req_valid = 1'b0;
    endtask

    task automatic r_beat(input logic [31:0] d, input logic [1:0] resp, input logic last);
        check("rready_during_beat", RREADY, 1'b1);
        RVALID = 1'b1; RDATA = d; RRESP = resp; RLAST = last;
        @(negedge ACLK);
        RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
    endtask

    initial begin
        ARESETn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        req_wstrb = '0; req_wdata = '0;
        ARREADY = 1'b1; AWREADY = 1'b1; WREADY = 1'b1;
        RVALID = 1'b0; RID = '0; RDATA = '0; RRESP = '0; RLAST = 1'b0;
        BVALID = 1'b0; BID = '0; BRESP = '0;
        repeat (2) @(negedge ACLK);
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_valids", {ARVALID, AWVALID, WVALID, RREADY, BREADY, rsp_valid, rsp_err}, 7'b0);
        check("rst_rsp_rdata", rsp_rdata, 128'h0);
        check("rst_ax_fields", {ARADDR, ARLEN, ARSIZE, ARBURST, ARID, WDATA}, 77'h0);
        ARESETn = 1'b1;
        @(negedge ACLK);
        check("req_ready_after_reset", req_ready, 1'b1);

        // four-beat read, zero-wait slave
        send_req(1'b0, 32'h0000_1000, 2'd3, 4'h0, '0);
        check("rd_arvalid", ARVALID, 1'b1);
        check("rd_ar_fields", {ARADDR, ARLEN, ARSIZE, ARBURST, ARID}, {32'h1000, 4'd3, 3'd2, 2'b01, 4'd0});
        check("rd_busy_ready", {busy, req_ready}, 2'b10);
        @(negedge ACLK);
        check("rd_arvalid_drop", ARVALID, 1'b0);
        r_beat(32'hA0, 2'b00, 1'b0);
        r_beat(32'hA1, 2'b00, 1'b0);
        r_beat(32'hA2, 2'b00, 1'b0);
        check("rd_no_early_rsp", rsp_valid, 1'b0);
        r_beat(32'hA3, 2'b00, 1'b1);
        check("rd_rsp_valid_T6", rsp_valid, 1'b1);
        check("rd_rsp_err", rsp_err, 1'b0);
        exp_line = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        check("rd_rdata", rsp_rdata, exp_line);
        @(negedge ACLK);
        check("rd_rsp_pulse_end", {rsp_valid, req_ready, busy}, 3'b010);

        // two-beat write, WREADY low two cycles per beat
        WREADY = 1'b0;
        send_req(1'b1, 32'h0000_4000, 2'd1, 4'b0011, {64'h0, 32'h2222_2222, 32'h1111_1111});
        check("wr_aw", {AWVALID, WVALID, AWADDR, AWLEN, AWSIZE, AWBURST}, {2'b10, 32'h4000, 4'd1, 3'd2, 2'b01});
        @(negedge ACLK);
        for (int i = 0; i < 3; i++) begin
            check("wr_beat0_stall", {WVALID, WLAST, WSTRB, WDATA}, {2'b10, 4'b0011, 32'h1111_1111});
            if (i < 2) @(negedge ACLK);
        end
        WREADY = 1'b1;
        @(negedge ACLK);
        WREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("wr_beat1_stall", {WVALID, WLAST, WSTRB, WDATA}, {2'b11, 4'b0011, 32'h2222_2222});
            if (i < 2) @(negedge ACLK);
        end
        WREADY = 1'b1;
        @(negedge ACLK);
        check("wr_b_phase", {WVALID, BREADY, rsp_valid}, 3'b010);
        BVALID = 1'b1;
        @(negedge ACLK);
        BVALID = 1'b0;
        check("wr_rsp", {rsp_valid, rsp_err}, 2'b10);
        check("wr_rdata_held", rsp_rdata, exp_line);
        @(negedge ACLK);

        // single-beat read with SLVERR
        send_req(1'b0, 32'h0000_2000, 2'd0, 4'h0, '0);
        check("rd1_arlen", {ARVALID, ARLEN}, {1'b1, 4'd0});
        @(negedge ACLK);
        r_beat(32'hBEEF, 2'b10, 1'b1);
        exp_line = {32'hA3, 32'hA2, 32'hA1, 32'hBEEF};
        check("rd1_rsp_err", {rsp_valid, rsp_err}, 2'b11);
        check("rd1_rdata", rsp_rdata, exp_line);
        @(negedge ACLK);

        // early RLAST on beat 1 of 4
        send_req(1'b0, 32'h0000_2010, 2'd3, 4'h0, '0);
        @(negedge ACLK);
        r_beat(32'hC0, 2'b00, 1'b0);
        r_beat(32'hC1, 2'b00, 1'b1);
        exp_line = {32'hA3, 32'hA2, 32'hC1, 32'hC0};
        check("early_last_rsp", {rsp_valid, rsp_err}, 2'b11);
        check("early_last_rdata", rsp_rdata, exp_line);
        @(negedge ACLK);
        check("early_last_idle", {req_ready, busy}, 2'b10);

        // ARREADY held low for ten cycles
        ARREADY = 1'b0;
        send_req(1'b0, 32'h0000_3000, 2'd0, 4'h0, '0);
        for (int i = 0; i < 10; i++) begin
            check("ar_stall", {ARVALID, ARADDR, busy, req_ready}, {1'b1, 32'h3000, 2'b10});
            @(negedge ACLK);
        end
        ARREADY = 1'b1;
        @(negedge ACLK);
        r_beat(32'hD0, 2'b00, 1'b1);
        exp_line = {32'hA3, 32'hA2, 32'hC1, 32'hD0};
        check("ar_stall_rsp", {rsp_valid, rsp_err}, 2'b10);
        check("ar_stall_rdata", rsp_rdata, exp_line);
        @(negedge ACLK);

        // slave keeps streaming past len: beats after the overrun are dropped
        send_req(1'b0, 32'h0000_3100, 2'd1, 4'h0, '0);
        @(negedge ACLK);
        r_beat(32'hE0, 2'b00, 1'b0);
        r_beat(32'hE1, 2'b00, 1'b0);
        check("overrun_wait", rsp_valid, 1'b0);
        r_beat(32'hE2, 2'b00, 1'b1);
        exp_line = {32'hA3, 32'hA2, 32'hE1, 32'hE0};
        check("overrun_rsp", {rsp_valid, rsp_err}, 2'b11);
        check("overrun_rdata", rsp_rdata, exp_line);
        @(negedge ACLK);

        // reset pulsed during the W phase
        WREADY = 1'b0;
        send_req(1'b1, 32'h0000_5000, 2'd1, 4'hF, {64'h0, 32'h5555_5555, 32'h4444_4444});
        @(negedge ACLK);
        check("mid_w_wvalid", WVALID, 1'b1);
        #2 ARESETn = 1'b0;
        #1;
        check("mid_w_async_reset", {ARVALID, AWVALID, WVALID, BREADY, RREADY, busy, req_ready, rsp_valid}, 8'b0);
        check("mid_w_rdata_cleared", rsp_rdata, 128'h0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        WREADY = 1'b1;
        @(negedge ACLK);
        check("post_reset_idle", {req_ready, rsp_valid, busy}, 3'b100);
        send_req(1'b1, 32'h0000_6000, 2'd0, 4'hF, {96'h0, 32'hCAFE_F00D});
        check("post_reset_aw", {AWVALID, AWADDR}, {1'b1, 32'h6000});
        @(negedge ACLK);
        check("post_reset_w", {WVALID, WLAST, WDATA}, {2'b11, 32'hCAFE_F00D});
        @(negedge ACLK);
        check("post_reset_bready", BREADY, 1'b1);
        BVALID = 1'b1;
        @(negedge ACLK);
        BVALID = 1'b0;
        check("post_reset_rsp", {rsp_valid, rsp_err}, 2'b10);
        @(negedge ACLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
